lut_layer_stream: RTL
=====================

LUT_LAYER_STREAM -- requirements
Module: lut_layer_stream

Interface
REQ-001 Parameter NUM_NEURONS, default 4, sets the number of LUT neurons in the layer.
REQ-002 Parameter FAN_IN, default 6, sets the input bits per neuron; each table has 2^FAN_IN entries.
REQ-003 Parameter OUT_BITS, default 1, sets the output bits per neuron and the width of each table entry.
REQ-004 Port clk  in  1  single clock; all state on rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port in_valid  in  1  input vector valid.
REQ-007 Port in_ready  out  1  block accepts input this cycle.
REQ-008 Port in_data  in  NUM_NEURONS*FAN_IN  input vector; neuron k addresses its table with in_data[k*FAN_IN +: FAN_IN].
REQ-009 Port out_valid  out  1  output vector valid.
REQ-010 Port out_ready  in  1  downstream accepts output.
REQ-011 Port out_data  out  NUM_NEURONS*OUT_BITS  neuron k result in out_data[k*OUT_BITS +: OUT_BITS].
REQ-012 Port cfg_valid  in  1  config entry valid.
REQ-013 Port cfg_ready  out  1  config entry accepted this cycle.
REQ-014 Port cfg_data  in  OUT_BITS  one table entry.
REQ-015 Port cfg_last  in  1  marks final entry of a load.
REQ-016 Port cfg_err  out  1  sticky load-length error flag.

Function
REQ-017 FSM states: UNCFG, LOAD, RUN; reset state UNCFG.
REQ-018 Config order: neuron 0 entry 0..2^FAN_IN-1, then neuron 1, ...; total TOTAL = NUM_NEURONS*2^FAN_IN beats; write pointer counts 0..TOTAL-1.
REQ-019 cfg_ready = 1 in UNCFG and LOAD; in RUN, cfg_ready = 1 only when out_valid = 0.
REQ-020 An accepted cfg beat in UNCFG or RUN writes entry 0, sets pointer to 1, clears cfg_err, enters LOAD (if TOTAL = 1 and cfg_last = 1, go straight to RUN).
REQ-021 In LOAD, each accepted beat writes entry[pointer] and increments pointer.
REQ-022 Beat at pointer TOTAL-1 with cfg_last = 1 -> RUN; pointer returns to 0.
REQ-023 cfg_last = 1 before pointer TOTAL-1, or cfg_last = 0 at pointer TOTAL-1 -> entry still written, cfg_err = 1, state UNCFG, pointer 0.
REQ-024 in_ready = 1 only in RUN with cfg_valid = 0 and (out_valid = 0 or out_ready = 1); config has priority over data.
REQ-025 Latency 1: input accepted at edge N -> out_valid = 1 and out_data = table lookups of that vector after edge N.
REQ-026 out_valid/out_data hold stable while out_valid = 1 and out_ready = 0.
REQ-027 Simultaneous output drain and input accept -> out_valid stays 1, out_data updates; back-to-back throughput 1 vector/cycle.
REQ-028 Output drained with no new accept -> out_valid = 0, out_data holds last value.
REQ-029 Tables are not modified in RUN except via a new load (REQ-020); a new load starts only when the output register is empty.

Reset
REQ-030 rst_n low asynchronously forces: state UNCFG, pointer 0, out_valid 0, out_data 0, cfg_err 0, all table entries 0; in_ready 0, cfg_ready 1 during and after reset.
REQ-031 Reset mid-load or mid-stream discards the partial load and any held output; full reload required.

Structure
REQ-032 Package lut_layer_pkg holds the FSM state enum and the TOTAL / pointer-width (clog2 of TOTAL, min 1) derivation functions.
REQ-033 One sub-module lut_neuron_cfg: single neuron table (2^FAN_IN x OUT_BITS flops), write port (en, addr, data), combinational read by FAN_IN address; top instantiates NUM_NEURONS copies.

Verification (defaults 4/6/1)
REQ-034 After reset: out_valid 0, in_ready 0, cfg_ready 1, cfg_err 0; in_valid = 1 with in_data = 0xFFFFFF -> no accept.
REQ-035 Load 256 beats, neuron k entry i = bit k of i, cfg_last on beat 255 -> RUN; in_data = {6'h08,6'h04,6'h02,6'h01} (neuron 3..0) -> next cycle out_data = 4'b1111, out_valid 1.
REQ-036 Same tables, out_ready = 0 for 3 cycles with in_valid held -> in_ready 0, out_data stable; out_ready 1 then streams 4 vectors back-to-back, one per cycle, in order.
REQ-037 cfg_last on beat 100 -> cfg_err 1, state UNCFG, in_ready 0; a correct 256-beat reload clears cfg_err and returns to RUN.
REQ-038 cfg_valid asserted in RUN while out_valid = 1, out_ready = 0 -> cfg_ready 0 and in_ready 0 until drained, then load proceeds.
REQ-039 rst_n pulsed low at load beat 50 -> all outputs reset immediately; tables read 0 after the next full load of zeros.

Source files
------------

// File: rtl/lut_layer_pkg.sv
// Shared types and size derivations for the streaming LUT layer.
package lut_layer_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic int unsigned lut_total(input int unsigned num_neurons,
                                            input int unsigned fan_in);
    return num_neurons * (32'd1 << fan_in);
  endfunction

  function automatic int unsigned lut_ptr_w(input int unsigned total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/lut_neuron_cfg.sv
// One neuron truth table: flop array with a single write port and a
// combinational read addressed by the neuron's input bits.
module lut_neuron_cfg
  import lut_layer_pkg::*;
#(
  parameter int FAN_IN   = 6,
  parameter int OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [FAN_IN-1:0]   addr,
  input  logic [OUT_BITS-1:0] data,
  input  logic [FAN_IN-1:0]   raddr,
  output logic [OUT_BITS-1:0] rdata
);

  localparam int unsigned DEPTH = 32'd1 << FAN_IN;

  logic [OUT_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[addr] <= data;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_layer_stream.sv
// Layer of LUT neurons with a serial table-load port and a one-deep
// registered valid/ready output stage.
module lut_layer_stream
  import lut_layer_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int FAN_IN      = 6,
  parameter int OUT_BITS    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*FAN_IN-1:0]   in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [OUT_BITS-1:0]             cfg_data,
  input  logic                            cfg_last,
  output logic                            cfg_err
);

  localparam int unsigned TOTAL = lut_total(NUM_NEURONS, FAN_IN);
  localparam int          PW    = lut_ptr_w(TOTAL);

  state_t                          state, state_nx;
  logic [PW-1:0]                   ptr, ptr_nx, wptr;
  logic                            err_nx, at_end;
  logic                            cfg_fire, in_fire;
  logic [NUM_NEURONS*OUT_BITS-1:0] lookup;

  assign cfg_ready = (state != RUN) || !out_valid;
  assign in_ready  = (state == RUN) && !cfg_valid && (!out_valid || out_ready);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;

  // A beat outside LOAD always restarts the load at entry 0.
  assign wptr   = (state == LOAD) ? ptr : '0;
  assign at_end = (wptr == PW'(TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UNCFG;
      ptr     <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      cfg_err <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    err_nx   = cfg_err;
    if (cfg_fire) begin
      if (state != LOAD) err_nx = 1'b0;
      if (at_end && cfg_last) begin
        state_nx = RUN;
        ptr_nx   = '0;
      end else if (at_end || cfg_last) begin
        state_nx = UNCFG;
        ptr_nx   = '0;
        err_nx   = 1'b1;
      end else begin
        state_nx = LOAD;
        ptr_nx   = wptr + PW'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_neuron
    logic we;
    assign we = cfg_fire && ((wptr >> FAN_IN) == PW'(k));

    lut_neuron_cfg #(
      .FAN_IN   (FAN_IN),
      .OUT_BITS (OUT_BITS)
    ) u_lut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (we),
      .addr  (wptr[FAN_IN-1:0]),
      .data  (cfg_data),
      .raddr (in_data[k*FAN_IN +: FAN_IN]),
      .rdata (lookup[k*OUT_BITS +: OUT_BITS])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= lookup;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
